// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron multiply-accumulate stage.
//   neuron_state_t : evaluation FSM states
//   sat_add        : add two signed values and clamp the result to a signed range of `width` bits
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } neuron_state_t;

    // Working width of sat_add; wide enough that the raw sum of any operand pair in use
    // (accumulator or full product plus one carry bit) never wraps before clamping.
    localparam int unsigned SAT_WIDTH = 64;

    function automatic logic signed [SAT_WIDTH-1:0] sat_add(
        input logic signed [SAT_WIDTH-1:0] a,
        input logic signed [SAT_WIDTH-1:0] b,
        input int unsigned                 width
    );
        logic signed [SAT_WIDTH-1:0] s;
        logic signed [SAT_WIDTH-1:0] hi;
        logic signed [SAT_WIDTH-1:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/neuron_weight_bank.sv
// Weight and bias storage for one neuron.
// Entries 0..NUM_INPUTS-1 hold weights, entry NUM_INPUTS holds the bias.
//   clock, reset : rising-edge clock, asynchronous active-high clear of every entry
//   we           : write strobe (caller gates it to the idle state)
//   w_addr       : write address; addresses above NUM_INPUTS are dropped
//   w_data       : signed write data
//   rd_addr      : asynchronous weight read address
//   rd_data      : weight at rd_addr
//   bias         : bias entry
module neuron_weight_bank
    import neuron_pkg::*;
#(
    parameter int unsigned NUM_INPUTS   = 16,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH   = $clog2(NUM_INPUTS + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           we,
    input  logic        [ADDR_WIDTH-1:0]   w_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] w_data,
    input  logic        [ADDR_WIDTH-1:0]   rd_addr,
    output logic signed [WEIGHT_WIDTH-1:0] rd_data,
    output logic signed [WEIGHT_WIDTH-1:0] bias
);

    logic signed [WEIGHT_WIDTH-1:0] mem_q [NUM_INPUTS+1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= int'(NUM_INPUTS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (w_addr <= ADDR_WIDTH'(NUM_INPUTS))) begin
            mem_q[w_addr] <= w_data;
        end
    end

    assign rd_data = mem_q[rd_addr];
    assign bias    = mem_q[NUM_INPUTS];

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate stage feeding the activation stage.
// After start, accepts NUM_INPUTS activations, accumulates (x * w) >>> FRAC_BITS onto the bias
// with saturation, then publishes the sum with a one-cycle sum_valid pulse.
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   w_we/w_addr/w_data : weight (addr < NUM_INPUTS) or bias (addr == NUM_INPUTS) write, idle only
//   start              : begin an evaluation (ignored while busy)
//   in_data/in_valid   : activation stream; in_ready is high only while accumulating
//   busy               : evaluation in progress
//   act_clear          : one-cycle pulse clearing the downstream activation output
//   sum/sum_valid      : registered signed result and its one-cycle qualifier
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int unsigned NUM_INPUTS   = 16,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned FRAC_BITS    = 8
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   w_we,
    input  logic        [$clog2(NUM_INPUTS+1)-1:0] w_addr,
    input  logic signed [WEIGHT_WIDTH-1:0]         w_data,
    input  logic                                   start,
    input  logic signed [DATA_WIDTH-1:0]           in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic                                   busy,
    output logic                                   act_clear,
    output logic signed [ACC_WIDTH-1:0]            sum,
    output logic                                   sum_valid
);

    localparam int unsigned ADDR_WIDTH = $clog2(NUM_INPUTS + 1);
    localparam int unsigned PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;

    neuron_state_t                  state_q, state_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic        [ADDR_WIDTH-1:0]   index_q, index_d;
    logic signed [ACC_WIDTH-1:0]    sum_q, sum_d;
    logic                           sum_valid_q, sum_valid_d;
    logic                           act_clear_q, act_clear_d;

    logic                           bank_we;
    logic signed [WEIGHT_WIDTH-1:0] weight;
    logic signed [WEIGHT_WIDTH-1:0] bias;
    logic signed [WEIGHT_WIDTH-1:0] bias_eff;
    logic signed [PROD_WIDTH-1:0]   product;
    logic signed [PROD_WIDTH-1:0]   term;

    assign bank_we = w_we && (state_q == IDLE);

    neuron_weight_bank #(
        .NUM_INPUTS  (NUM_INPUTS),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_bank (
        .clock  (clock),
        .reset  (reset),
        .we     (bank_we),
        .w_addr (w_addr),
        .w_data (w_data),
        .rd_addr(index_q),
        .rd_data(weight),
        .bias   (bias)
    );

    // A bias write in the same cycle as start must be seen by that evaluation.
    assign bias_eff = (bank_we && (w_addr == ADDR_WIDTH'(NUM_INPUTS))) ? w_data : bias;

    assign product = PROD_WIDTH'(in_data) * PROD_WIDTH'(weight);
    assign term    = product >>> FRAC_BITS;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        index_d     = index_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        act_clear_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d       = ACC_WIDTH'(bias_eff);
                    index_d     = '0;
                    act_clear_d = 1'b1;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = ACC_WIDTH'(sat_add(SAT_WIDTH'(acc_q), SAT_WIDTH'(term), ACC_WIDTH));
                    index_d = index_q + 1'b1;
                    if (index_q == ADDR_WIDTH'(NUM_INPUTS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                sum_d       = acc_q;
                sum_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            index_q     <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            act_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            index_q     <= index_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            act_clear_q <= act_clear_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign act_clear = act_clear_q;
    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
module tb_neuron_mac;

    localparam int NI  = 4;
    localparam int DW  = 16;
    localparam int WW  = 16;
    localparam int ACW = 20;
    localparam int FB  = 8;
    localparam int AWD = $clog2(NI + 1);

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  w_we;
    logic [AWD-1:0]        w_addr;
    logic signed [WW-1:0]  w_data;
    logic                  start;
    logic signed [DW-1:0]  in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  busy;
    logic                  act_clear;
    logic signed [ACW-1:0] sum;
    logic                  sum_valid;

    neuron_mac #(
        .NUM_INPUTS  (NI),
        .DATA_WIDTH  (DW),
        .WEIGHT_WIDTH(WW),
        .ACC_WIDTH   (ACW),
        .FRAC_BITS   (FB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .act_clear(act_clear),
        .sum      (sum),
        .sum_valid(sum_valid)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Pulse counters, sampled mid-cycle; tasks compare deltas.
    int ac_cnt  = 0;
    int sv_cnt  = 0;
    int overlap = 0;
    always @(negedge clock) begin
        if (!reset) begin
            if (act_clear) ac_cnt++;
            if (sum_valid) sv_cnt++;
            if (act_clear && sum_valid) overlap++;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: bias plus floor-shifted products, clamped after every term.
    function automatic longint model(input int w[NI], input int b, input int x[NI]);
        longint acc;
        longint hi;
        longint lo;
        hi  = (longint'(1) <<< (ACW - 1)) - 1;
        lo  = -(longint'(1) <<< (ACW - 1));
        acc = b;
        for (int i = 0; i < NI; i++) begin
            acc = acc + ((longint'(x[i]) * longint'(w[i])) >>> FB);
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
        end
        return acc;
    endfunction

    task automatic write_weight(input int addr, input int data);
        w_we   = 1'b1;
        w_addr = AWD'(addr);
        w_data = WW'(data);
        @(posedge clock); #1;
        w_we   = 1'b0;
    endtask

    // mode: 0 back-to-back, 1 gap pattern, 2 random gaps,
    //       3 start/w_we disturbance mid-accumulation, 4 bias written together with start
    task automatic run_eval(input int w[NI], input int b, input int x[NI], input int mode,
                            input bit load, input longint exp, input string tag);
        int pat[7];
        int k, cyc, d;
        int ac0, sv0, ov0;
        bit beat;
        pat = '{1, 0, 0, 1, 0, 1, 1};
        if (load) begin
            for (int i = 0; i < NI; i++) write_weight(i, w[i]);
            if (mode != 4) write_weight(NI, b);
        end
        ac0 = ac_cnt; sv0 = sv_cnt; ov0 = overlap;
        start = 1'b1;
        if (mode == 4) begin
            w_we = 1'b1; w_addr = AWD'(NI); w_data = WW'(b);
        end
        @(posedge clock); #1;
        start = 1'b0; w_we = 1'b0;
        check({tag, "_act_clear"}, act_clear, 1);
        check({tag, "_busy_run"}, busy, 1);
        k = 0; cyc = 0; d = 0;
        while (k < NI && cyc < 40) begin
            case (mode)
                1:       in_valid = pat[cyc % 7] != 0;
                2:       in_valid = ($urandom_range(0, 2) != 0);
                default: in_valid = 1'b1;
            endcase
            if (mode == 3 && k == 2 && d < 2) begin
                in_valid = 1'b0;
                start    = 1'b1;
                w_we     = 1'b1;
                w_addr   = (d == 0) ? AWD'(NI) : AWD'(3);
                w_data   = 16'sd1000;
                d++;
            end
            in_data = DW'(x[k < NI ? k : 0]);
            beat = in_valid && in_ready;
            @(posedge clock); #1;
            start = 1'b0; w_we = 1'b0;
            if (beat) k++;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_beats"}, k, NI);
        check({tag, "_no_early_valid"}, sum_valid, 0);
        @(posedge clock); #1;
        check({tag, "_sum_valid"}, sum_valid, 1);
        check({tag, "_sum"}, sum, exp);
        check({tag, "_busy_done"}, busy, 0);
        @(posedge clock); #1;
        check({tag, "_valid_pulse"}, sum_valid, 0);
        check({tag, "_sum_hold"}, sum, exp);
        check({tag, "_act_clear_count"}, ac_cnt - ac0, 1);
        check({tag, "_sum_valid_count"}, sv_cnt - sv0, 1);
        check({tag, "_overlap"}, overlap - ov0, 0);
    endtask

    typedef struct {
        int     w[NI];
        int     bias;
        int     x[NI];
        longint exp_sum;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   ones[NI];
        int   w[NI];
        int   x[NI];
        int   b;
        int   sv0;

        ones = '{256, 256, 256, 256};
        vecs[0].w = '{256, 256, 256, 256};     vecs[0].bias = 128;
        vecs[0].x = '{256, 512, 768, 1024};    vecs[0].exp_sum = 2688;
        vecs[1].w = '{-256, -256, -256, -256}; vecs[1].bias = 0;
        vecs[1].x = '{256, 512, 768, 1024};    vecs[1].exp_sum = -2560;
        vecs[2].w = '{32767, 32767, 32767, 32767}; vecs[2].bias = 0;
        vecs[2].x = '{32767, 32767, 32767, 32767}; vecs[2].exp_sum = 524287;
        vecs[3].w = '{-32768, -32768, -32768, -32768}; vecs[3].bias = 0;
        vecs[3].x = '{32767, 32767, 32767, 32767};     vecs[3].exp_sum = -524288;
        // Arithmetic shift floors toward minus infinity: -1 >>> 8 == -1.
        vecs[4].w = '{1, 1, 1, 1};             vecs[4].bias = 0;
        vecs[4].x = '{-1, -1, -1, -1};         vecs[4].exp_sum = -4;

        reset = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
        start = 1'b0; in_data = '0; in_valid = 1'b0;
        #1;
        check("reset_sum", sum, 0);
        check("reset_sum_valid", sum_valid, 0);
        check("reset_act_clear", act_clear, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 5; i++) begin
            run_eval(vecs[i].w, vecs[i].bias, vecs[i].x, 0, 1'b1, vecs[i].exp_sum,
                     $sformatf("vec%0d", i));
        end

        run_eval(vecs[0].w, 128, vecs[0].x, 1, 1'b1, 2688, "gaps");
        run_eval(vecs[0].w, 128, vecs[0].x, 3, 1'b1, 2688, "disturb");
        run_eval(vecs[0].w, 128, vecs[0].x, 0, 1'b0, 2688, "after_disturb");

        w = '{0, 0, 0, 0};
        run_eval(w, 77, vecs[0].x, 4, 1'b1, 77, "bias_with_start");
        run_eval(w, 77, vecs[0].x, 0, 1'b0, 77, "bias_kept");

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NI; i++) begin
                w[i] = int'($urandom_range(0, 65535)) - 32768;
                x[i] = (r % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                    : int'($urandom_range(0, 4095)) - 2048;
            end
            b = int'($urandom_range(0, 65535)) - 32768;
            run_eval(w, b, x, 2, 1'b1, model(w, b, x), $sformatf("rand%0d", r));
        end

        // Abort after two beats with asynchronous reset.
        for (int i = 0; i < NI; i++) write_weight(i, 256);
        write_weight(NI, 128);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'sd256;
        @(posedge clock); #1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        sv0 = sv_cnt;
        #2;
        reset = 1'b1;
        #1;
        check("abort_sum", sum, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_act_clear", act_clear, 0);
        check("abort_sum_valid", sum_valid, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("abort_no_valid", sv_cnt - sv0, 0);
        // Out-of-range addresses must not land anywhere.
        write_weight(5, 999);
        write_weight(6, 999);
        write_weight(7, 999);
        run_eval(w, 0, ones, 0, 1'b0, 0, "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
